// File: rtl/pcs_tx_oset_sched.sv
// 1000BASE-X PCS transmit ordered-set scheduler: shares one code-group slot between /C/, /I/ and framed packets.
// Define PCS_TX_OSET_STATS_EN to add saturating packet and underrun counters.
module pcs_tx_oset_sched #(
    parameter int IDLE_MIN = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       xmit,
    input  logic [15:0]      cfg_reg,
    input  logic             rd_pos,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    input  logic             tx_last,
    input  logic             tx_err,
    output logic             tx_ready,
    output logic [7:0]       tx_octet,
    output logic             tx_is_k,
    output logic             tx_even
`ifdef PCS_TX_OSET_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_pkt_cnt,
    output logic [CNT_W-1:0] stat_underrun_cnt
`endif
);

    // state    | meaning
    // BOUNDARY | next slot is even; pick /C/, /I/ or /S/ from xmit
    // IDLE2    | second octet of /I/ (I1 or I2 from rd_pos)
    // CFG1..3  | remaining octets of /C1/ or /C2/
    // DATA     | packet octets flowing, tx_ready high
    // DRAIN    | after underrun: swallow octets, send /V/ until tx_last
    // END_T    | send /T/
    // END_R    | send /R/; a second /R/ follows if this one is even
    // END_R2   | the extra /R/ that restores even alignment
    typedef enum logic [3:0] {
        ST_BOUNDARY,
        ST_IDLE2,
        ST_CFG1,
        ST_CFG2,
        ST_CFG3,
        ST_DATA,
        ST_DRAIN,
        ST_END_T,
        ST_END_R,
        ST_END_R2
    } state_t;

    localparam logic [1:0] XM_CONFIG = 2'b01;
    localparam logic [1:0] XM_DATA   = 2'b10;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K_S   = 8'hFB;
    localparam logic [7:0] K_T   = 8'hFD;
    localparam logic [7:0] K_R   = 8'hF7;
    localparam logic [7:0] K_V   = 8'hFE;
    localparam logic [7:0] D_C1  = 8'hB5;
    localparam logic [7:0] D_C2  = 8'h42;
    localparam logic [7:0] D_I1  = 8'hC5;
    localparam logic [7:0] D_I2  = 8'h50;

    localparam logic [3:0] IDLE_MIN_C = 4'(IDLE_MIN);

    state_t      state, state_nxt;
    logic [7:0]  octet_nxt;
    logic        k_nxt;
    logic [3:0]  idle_cnt, idle_cnt_nxt;
    logic [15:0] cfg_q, cfg_q_nxt;
    logic        cfg_c2, cfg_c2_nxt;

    // DRAIN keeps accepting so the MAC can flush the rest of the broken packet.
    assign tx_ready = (state == ST_DATA) || (state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOUNDARY;
            tx_octet <= 8'h00;
            tx_is_k  <= 1'b0;
            tx_even  <= 1'b0;
            idle_cnt <= 4'd0;
            cfg_q    <= 16'h0000;
            cfg_c2   <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_octet <= octet_nxt;
            tx_is_k  <= k_nxt;
            tx_even  <= ~tx_even;
            idle_cnt <= idle_cnt_nxt;
            cfg_q    <= cfg_q_nxt;
            cfg_c2   <= cfg_c2_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        octet_nxt    = 8'h00;
        k_nxt        = 1'b0;
        idle_cnt_nxt = idle_cnt;
        cfg_q_nxt    = cfg_q;
        cfg_c2_nxt   = cfg_c2;
        case (state)
            ST_BOUNDARY: begin
                if (xmit == XM_CONFIG) begin
                    octet_nxt = K28_5;
                    k_nxt     = 1'b1;
                    cfg_q_nxt = cfg_reg;
                    state_nxt = ST_CFG1;
                end else if (xmit == XM_DATA && tx_valid && idle_cnt >= IDLE_MIN_C) begin
                    octet_nxt  = K_S;
                    k_nxt      = 1'b1;
                    cfg_c2_nxt = 1'b0;
                    state_nxt  = ST_DATA;
                end else begin
                    octet_nxt  = K28_5;
                    k_nxt      = 1'b1;
                    cfg_c2_nxt = 1'b0;
                    state_nxt  = ST_IDLE2;
                end
            end
            ST_IDLE2: begin
                octet_nxt = rd_pos ? D_I1 : D_I2;
                if (idle_cnt != 4'hF) idle_cnt_nxt = idle_cnt + 4'd1;
                state_nxt = ST_BOUNDARY;
            end
            ST_CFG1: begin
                octet_nxt = cfg_c2 ? D_C2 : D_C1;
                state_nxt = ST_CFG2;
            end
            ST_CFG2: begin
                octet_nxt = cfg_q[7:0];
                state_nxt = ST_CFG3;
            end
            ST_CFG3: begin
                octet_nxt  = cfg_q[15:8];
                cfg_c2_nxt = ~cfg_c2;
                state_nxt  = ST_BOUNDARY;
            end
            ST_DATA: begin
                if (tx_valid) begin
                    octet_nxt = tx_err ? K_V : tx_data;
                    k_nxt     = tx_err;
                    if (tx_last) state_nxt = ST_END_T;
                end else begin
                    octet_nxt = K_V;
                    k_nxt     = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                octet_nxt = K_V;
                k_nxt     = 1'b1;
                if (tx_valid && tx_last) state_nxt = ST_END_T;
            end
            ST_END_T: begin
                octet_nxt    = K_T;
                k_nxt        = 1'b1;
                idle_cnt_nxt = 4'd0;
                state_nxt    = ST_END_R;
            end
            ST_END_R: begin
                octet_nxt = K_R;
                k_nxt     = 1'b1;
                // ~tx_even: the /R/ being launched now lands in an even slot
                state_nxt = (~tx_even) ? ST_END_R2 : ST_BOUNDARY;
            end
            ST_END_R2: begin
                octet_nxt = K_R;
                k_nxt     = 1'b1;
                state_nxt = ST_BOUNDARY;
            end
            default: state_nxt = ST_BOUNDARY;
        endcase
    end

`ifdef PCS_TX_OSET_STATS_EN
    logic pkt_inc, urun_inc;
    assign pkt_inc  = (state == ST_END_T);
    assign urun_inc = (state == ST_DATA) && !tx_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkt_cnt      <= '0;
            stat_underrun_cnt <= '0;
        end else begin
            if (pkt_inc && stat_pkt_cnt != '1)
                stat_pkt_cnt <= stat_pkt_cnt + CNT_W'(1);
            if (urun_inc && stat_underrun_cnt != '1)
                stat_underrun_cnt <= stat_underrun_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pcs_tx_oset_sched.sv
// Self-checking bench for pcs_tx_oset_sched: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_pcs_tx_oset_sched;

    localparam int IDLE_MIN = 1;
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  xmit;
    logic [15:0] cfg_reg;
    logic        rd_pos, tx_valid, tx_last, tx_err;
    logic [7:0]  tx_data;
    logic        tx_ready, tx_is_k, tx_even;
    logic [7:0]  tx_octet;
`ifdef PCS_TX_OSET_STATS_EN
    logic [15:0] stat_pkt_cnt, stat_underrun_cnt;
`endif

    always #5 clk = ~clk;

    pcs_tx_oset_sched #(.IDLE_MIN(IDLE_MIN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .xmit(xmit), .cfg_reg(cfg_reg), .rd_pos(rd_pos),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_err(tx_err),
        .tx_ready(tx_ready), .tx_octet(tx_octet), .tx_is_k(tx_is_k), .tx_even(tx_even)
`ifdef PCS_TX_OSET_STATS_EN
        , .stat_pkt_cnt(stat_pkt_cnt), .stat_underrun_cnt(stat_underrun_cnt)
`endif
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_out(input string name, input logic [7:0] eo, input logic ek,
                           input logic ee, input logic er);
        chk({name, ".octet"}, 32'(tx_octet), 32'(eo));
        chk({name, ".k"},     32'(tx_is_k),  32'(ek));
        chk({name, ".even"},  32'(tx_even),  32'(ee));
        chk({name, ".ready"}, 32'(tx_ready), 32'(er));
    endtask

    // Inputs change at the falling edge; outputs are observed one falling edge later.
    task automatic drive(input logic r, input logic [1:0] x, input logic rp, input logic v,
                         input logic [7:0] d, input logic l, input logic e);
        rst = r; xmit = x; rd_pos = rp; tx_valid = v; tx_data = d; tx_last = l; tx_err = e;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] x;
        logic       rp, v;
        logic [7:0] d;
        logic       l, e;
        logic [7:0] eo;
        logic       ek, ee, er;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] x, input logic rp, input logic v, input logic [7:0] d,
                                input logic l, input logic e, input logic [7:0] eo,
                                input logic ek, input logic ee, input logic er);
        vec_t t;
        t.x = x; t.rp = rp; t.v = v; t.d = d; t.l = l; t.e = e;
        t.eo = eo; t.ek = ek; t.ee = ee; t.er = er;
        return t;
    endfunction

    vec_t tbl[28];

    logic hs_par;
    task automatic hs(input string name, input logic [1:0] x, input logic v, input logic [7:0] d,
                      input logic l, input logic e, input logic [7:0] eo, input logic ek, input logic er);
        drive(N, x, N, v, d, l, e);
        chk_out(name, eo, ek, hs_par, er);
        hs_par = ~hs_par;
    endtask

    // Reference model: whole ordered sets are queued at boundaries; packets are framed octet by octet.
    logic [8:0] mq[$];
    logic       m_pkt, m_drain, m_ipend, m_cph;
    int         m_icnt, m_slot;
    logic [7:0] m_oct;
    logic       m_k, m_even, m_ready;

    task automatic model_step();
        logic [8:0] g;
        if (rst) begin
            mq.delete();
            m_pkt = 0; m_drain = 0; m_ipend = 0; m_cph = 0; m_icnt = 0; m_slot = 0;
            m_oct = 8'h00; m_k = 0; m_even = 0; m_ready = 0;
            return;
        end
        if (m_pkt) begin
            if (tx_valid) begin
                mq.push_back((m_drain || tx_err) ? {1'b1, 8'hFE} : {1'b0, tx_data});
                if (tx_last) begin
                    m_pkt = 0;
                    m_icnt = 0;
                    mq.push_back({1'b1, 8'hFD});
                    mq.push_back({1'b1, 8'hF7});
                    if (((m_slot + 2) % 2) == 0) mq.push_back({1'b1, 8'hF7});
                end
            end else begin
                mq.push_back({1'b1, 8'hFE});
                m_drain = 1;
            end
        end else if (m_ipend) begin
            mq.push_back({1'b0, rd_pos ? 8'hC5 : 8'h50});
            m_ipend = 0;
            if (m_icnt < 15) m_icnt++;
        end else if (mq.size() == 0) begin
            if (xmit == 2'b01) begin
                mq.push_back({1'b1, 8'hBC});
                mq.push_back({1'b0, m_cph ? 8'h42 : 8'hB5});
                mq.push_back({1'b0, cfg_reg[7:0]});
                mq.push_back({1'b0, cfg_reg[15:8]});
                m_cph = ~m_cph;
            end else begin
                m_cph = 0;
                if (xmit == 2'b10 && tx_valid && m_icnt >= IDLE_MIN) begin
                    mq.push_back({1'b1, 8'hFB});
                    m_pkt = 1;
                    m_drain = 0;
                end else begin
                    mq.push_back({1'b1, 8'hBC});
                    m_ipend = 1;
                end
            end
        end
        g = mq.pop_front();
        m_oct   = g[7:0];
        m_k     = g[8];
        m_even  = ((m_slot % 2) == 0);
        m_ready = m_pkt;
        m_slot++;
    endtask

    initial begin
        tbl[0]  = mk(2'b01, N, N, 8'h00, N, N, 8'hBC, Y, Y, N);
        tbl[1]  = mk(2'b01, N, N, 8'h00, N, N, 8'hB5, N, N, N);
        tbl[2]  = mk(2'b01, N, N, 8'h00, N, N, 8'h34, N, Y, N);
        tbl[3]  = mk(2'b01, N, N, 8'h00, N, N, 8'h12, N, N, N);
        tbl[4]  = mk(2'b01, N, N, 8'h00, N, N, 8'hBC, Y, Y, N);
        tbl[5]  = mk(2'b01, N, N, 8'h00, N, N, 8'h42, N, N, N);
        tbl[6]  = mk(2'b01, N, N, 8'h00, N, N, 8'h34, N, Y, N);
        tbl[7]  = mk(2'b01, N, N, 8'h00, N, N, 8'h12, N, N, N);
        tbl[8]  = mk(2'b00, N, N, 8'h00, N, N, 8'hBC, Y, Y, N);
        tbl[9]  = mk(2'b00, N, N, 8'h00, N, N, 8'h50, N, N, N);
        tbl[10] = mk(2'b00, N, N, 8'h00, N, N, 8'hBC, Y, Y, N);
        tbl[11] = mk(2'b00, Y, N, 8'h00, N, N, 8'hC5, N, N, N);
        tbl[12] = mk(2'b10, N, N, 8'h00, N, N, 8'hBC, Y, Y, N);
        tbl[13] = mk(2'b10, N, Y, 8'hAA, N, N, 8'h50, N, N, N);
        tbl[14] = mk(2'b10, N, Y, 8'hAA, N, N, 8'hFB, Y, Y, Y);
        tbl[15] = mk(2'b10, N, Y, 8'hAA, N, N, 8'hAA, N, N, Y);
        tbl[16] = mk(2'b10, N, Y, 8'hBB, N, N, 8'hBB, N, Y, Y);
        tbl[17] = mk(2'b10, N, Y, 8'hCC, Y, N, 8'hCC, N, N, N);
        tbl[18] = mk(2'b10, N, N, 8'h00, N, N, 8'hFD, Y, Y, N);
        tbl[19] = mk(2'b10, N, N, 8'h00, N, N, 8'hF7, Y, N, N);
        tbl[20] = mk(2'b10, N, Y, 8'h11, N, N, 8'hBC, Y, Y, N);
        tbl[21] = mk(2'b10, N, Y, 8'h11, N, N, 8'h50, N, N, N);
        tbl[22] = mk(2'b10, N, Y, 8'h11, N, N, 8'hFB, Y, Y, Y);
        tbl[23] = mk(2'b10, N, Y, 8'h11, N, N, 8'h11, N, N, Y);
        tbl[24] = mk(2'b10, N, Y, 8'h22, N, Y, 8'hFE, Y, Y, Y);
        tbl[25] = mk(2'b10, N, Y, 8'h33, Y, N, 8'h33, N, N, N);
        tbl[26] = mk(2'b10, N, N, 8'h00, N, N, 8'hFD, Y, Y, N);
        tbl[27] = mk(2'b10, N, N, 8'h00, N, N, 8'hF7, Y, N, N);

        cfg_reg = 16'h1234;
        drive(Y, 2'b00, N, N, 8'h00, N, N);
        drive(Y, 2'b00, N, N, 8'h00, N, N);
        chk_out("reset", 8'h00, N, N, N);
`ifdef PCS_TX_OSET_STATS_EN
        chk("reset.stat_pkt", 32'(stat_pkt_cnt), 32'd0);
        chk("reset.stat_urun", 32'(stat_underrun_cnt), 32'd0);
`endif

        for (int i = 0; i < 28; i++) begin
            drive(N, tbl[i].x, tbl[i].rp, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].e);
            chk_out($sformatf("tbl%0d", i), tbl[i].eo, tbl[i].ek, tbl[i].ee, tbl[i].er);
        end

        hs_par = 1'b1;
        hs("urun0", 2'b10, Y, 8'hD0, N, N, 8'hBC, Y, N);
        hs("urun1", 2'b10, Y, 8'hD0, N, N, 8'h50, N, N);
        hs("urun2", 2'b10, Y, 8'hD0, N, N, 8'hFB, Y, Y);
        hs("urun3", 2'b10, Y, 8'hD0, N, N, 8'hD0, N, Y);
        hs("urun4", 2'b10, Y, 8'hD1, N, N, 8'hD1, N, Y);
        hs("urun5", 2'b10, N, 8'h00, N, N, 8'hFE, Y, Y);
        hs("urun6", 2'b10, Y, 8'h99, N, N, 8'hFE, Y, Y);
        hs("urun7", 2'b10, Y, 8'h9A, Y, N, 8'hFE, Y, N);
        hs("urun8", 2'b10, N, 8'h00, N, N, 8'hFD, Y, N);
        hs("urun9", 2'b10, N, 8'h00, N, N, 8'hF7, Y, N);
`ifdef PCS_TX_OSET_STATS_EN
        chk("stat_pkt", 32'(stat_pkt_cnt), 32'd3);
        chk("stat_urun", 32'(stat_underrun_cnt), 32'd1);
`endif

        hs("xr0", 2'b10, Y, 8'hE1, N, N, 8'hBC, Y, N);
        hs("xr1", 2'b10, Y, 8'hE1, N, N, 8'h50, N, N);
        hs("xr2", 2'b10, Y, 8'hE1, N, N, 8'hFB, Y, Y);
        hs("xr3", 2'b10, Y, 8'hE1, N, N, 8'hE1, N, Y);
        hs("xr4", 2'b10, Y, 8'hE2, Y, N, 8'hE2, N, N);
        hs("xr5", 2'b10, N, 8'h00, N, N, 8'hFD, Y, N);
        hs("xr6", 2'b10, N, 8'h00, N, N, 8'hF7, Y, N);
        hs("xr7", 2'b10, N, 8'h00, N, N, 8'hF7, Y, N);
        hs("xr8", 2'b10, N, 8'h00, N, N, 8'hBC, Y, N);
        hs("xr9", 2'b10, N, 8'h00, N, N, 8'h50, N, N);

        hs("sw0", 2'b10, Y, 8'hA1, N, N, 8'hFB, Y, Y);
        hs("sw1", 2'b10, Y, 8'hA1, N, N, 8'hA1, N, Y);
        hs("sw2", 2'b01, Y, 8'hA2, Y, N, 8'hA2, N, N);
        hs("sw3", 2'b01, N, 8'h00, N, N, 8'hFD, Y, N);
        hs("sw4", 2'b01, N, 8'h00, N, N, 8'hF7, Y, N);
        hs("sw5", 2'b01, N, 8'h00, N, N, 8'hF7, Y, N);
        hs("sw6", 2'b01, N, 8'h00, N, N, 8'hBC, Y, N);
        hs("sw7", 2'b01, N, 8'h00, N, N, 8'hB5, N, N);
        drive(Y, 2'b01, N, N, 8'h00, N, N);
        chk_out("midrst", 8'h00, N, N, N);
        hs_par = 1'b1;
        hs("rs0", 2'b01, N, 8'h00, N, N, 8'hBC, Y, N);
        hs("rs1", 2'b01, N, 8'h00, N, N, 8'hB5, N, N);
        hs("rs2", 2'b01, N, 8'h00, N, N, 8'h34, N, N);
        hs("rs3", 2'b01, N, 8'h00, N, N, 8'h12, N, N);

        for (int i = 0; i < 4000; i++) begin
            rst = (i == 0) || ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 5))
                    0: xmit = 2'b00;
                    1: xmit = 2'b01;
                    5: xmit = 2'b11;
                    default: xmit = 2'b10;
                endcase
            end
            cfg_reg  = 16'($urandom);
            rd_pos   = 1'($urandom);
            tx_valid = ($urandom_range(0, 9) < 8);
            tx_data  = 8'($urandom);
            tx_last  = ($urandom_range(0, 5) == 0);
            tx_err   = ($urandom_range(0, 15) == 0);
            model_step();
            @(negedge clk);
            chk_out($sformatf("rnd%0d", i), m_oct, m_k, m_even, m_ready);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
